rsa_modexp_core: RTL and testbench

//   Parametrised RSA modular-exponentiation engine: msg_out = msg_in^k mod n. k is key_e when encrypt_decrypt=1, key_d when 0.

---
 rtl/rsa_pkg.sv | 27 ++
 rtl/rsa_mod_mul.sv | 77 +++++++
 rtl/rsa_modexp_core.sv | 158 +++++++++++++++
 tb/tb_rsa_modexp_core.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/rsa_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rsa_pkg
// Description : Shared state encoding, default sizes and latency helper for
//               the RSA modular-exponentiation core.
// Revision    : 1.0 - initial release
// ============================================================================
package rsa_pkg;

    localparam int DEFAULT_WIDTH     = 256;
    localparam int DEFAULT_EXP_WIDTH = 256;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CHECK = 3'd1,
        MUL   = 3'd2,
        NEXT  = 3'd3,
        DONE  = 3'd4
    } state_t;

    // Start-accept edge to done-high, constant-time build.
    function automatic int fixed_latency(input int width, input int exp_width);
        return 2 + exp_width * (width + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/rsa_mod_mul.sv
`default_nettype none
// ============================================================================
// Module      : rsa_mod_mul
// Description : Bit-serial shift-add modular multiplier, p = a*b mod n, MSB
//               first, exactly WIDTH cycles. Requires a, b < n, WIDTH >= 2.
// Revision    : 1.0 - initial release
// ============================================================================
module rsa_mod_mul
    import rsa_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] n,
    output logic             done,
    output logic [WIDTH-1:0] p
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [CNT_W-1:0] r_cnt;
    logic             r_run;

    logic             w_bit;
    logic [WIDTH-1:0] w_acc_in;
    logic [WIDTH-1:0] w_b;
    logic [WIDTH+1:0] w_n;
    logic [WIDTH+1:0] w_sum;
    logic [WIDTH+1:0] w_s1;
    logic [WIDTH+1:0] w_s2;

    // The first step runs in the start cycle itself, straight from the inputs.
    always_comb begin
        w_bit    = start ? a[WIDTH-1] : r_a[WIDTH-1];
        w_acc_in = start ? '0 : r_acc;
        w_b      = start ? b : r_b;
        w_n      = {2'b00, n};
        w_sum    = {1'b0, w_acc_in, 1'b0} + {2'b00, (w_bit ? w_b : '0)};
        w_s1     = (w_sum >= w_n) ? (w_sum - w_n) : w_sum;
        w_s2     = (w_s1 >= w_n) ? (w_s1 - w_n) : w_s1;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_acc <= '0;
            r_a   <= '0;
            r_b   <= '0;
            r_cnt <= '0;
            r_run <= 1'b0;
        end else if (start) begin
            r_acc <= w_s2[WIDTH-1:0];
            r_a   <= a << 1;
            r_b   <= b;
            r_cnt <= CNT_W'(1);
            r_run <= 1'b1;
        end else if (r_run) begin
            r_acc <= w_s2[WIDTH-1:0];
            r_a   <= r_a << 1;
            r_cnt <= r_cnt + CNT_W'(1);
            if (r_cnt == CNT_W'(WIDTH - 1))
                r_run <= 1'b0;
        end
    end

    // High during the final step; p is valid from the following cycle.
    assign done = r_run && (r_cnt == CNT_W'(WIDTH - 1));
    assign p    = r_acc;

endmodule
`default_nettype wire

// File: rtl/rsa_modexp_core.sv
`default_nettype none
// ============================================================================
// Module      : rsa_modexp_core
// Description : Right-to-left square-and-multiply modular exponentiation,
//               msg_out = msg_in^k mod n. Optional macro
//               RSA_MODEXP_EARLY_EXIT_EN stops once the exponent is exhausted.
// Revision    : 1.0 - initial release
// ============================================================================
module rsa_modexp_core
    import rsa_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int EXP_WIDTH = DEFAULT_EXP_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 encrypt_decrypt,
    input  logic [WIDTH-1:0]     n,
    input  logic [EXP_WIDTH-1:0] key_e,
    input  logic [EXP_WIDTH-1:0] key_d,
    input  logic [WIDTH-1:0]     msg_in,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    output logic [WIDTH-1:0]     msg_out
);

    localparam int CNT_W = $clog2(EXP_WIDTH) + 1;

    state_t               r_state;
    state_t               w_state_next;
    logic [WIDTH-1:0]     r_n;
    logic [WIDTH-1:0]     r_base;
    logic [WIDTH-1:0]     r_result;
    logic [EXP_WIDTH-1:0] r_exp;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_err;
    logic                 r_mul_first;

    logic                 w_bad;
    logic                 w_mul_start;
    logic                 w_done_a;
    logic                 w_done_b;
    logic                 w_mul_done;
    logic [WIDTH-1:0]     w_p_a;
    logic [WIDTH-1:0]     w_p_b;

    assign w_bad       = (r_n < WIDTH'(2)) || (r_base >= r_n);
    assign w_mul_start = (r_state == MUL) && r_mul_first;
    assign w_mul_done  = w_done_a && w_done_b;

    rsa_mod_mul #(.WIDTH(WIDTH)) u_mul_a (
        .clk   (clk),
        .reset (reset),
        .start (w_mul_start),
        .a     (r_result),
        .b     (r_base),
        .n     (r_n),
        .done  (w_done_a),
        .p     (w_p_a)
    );

    rsa_mod_mul #(.WIDTH(WIDTH)) u_mul_b (
        .clk   (clk),
        .reset (reset),
        .start (w_mul_start),
        .a     (r_base),
        .b     (r_base),
        .n     (r_n),
        .done  (w_done_b),
        .p     (w_p_b)
    );

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:  if (start) w_state_next = CHECK;
            CHECK: begin
                if (w_bad)
                    w_state_next = DONE;
`ifdef RSA_MODEXP_EARLY_EXIT_EN
                else if (r_exp == '0)
                    w_state_next = DONE;
`endif
                else
                    w_state_next = MUL;
            end
            MUL:   if (w_mul_done) w_state_next = NEXT;
            NEXT: begin
                if (r_cnt == CNT_W'(EXP_WIDTH - 1))
                    w_state_next = DONE;
`ifdef RSA_MODEXP_EARLY_EXIT_EN
                else if ((r_exp >> 1) == '0)
                    w_state_next = DONE;
`endif
                else
                    w_state_next = MUL;
            end
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_n         <= '0;
            r_base      <= '0;
            r_result    <= '0;
            r_exp       <= '0;
            r_cnt       <= '0;
            r_err       <= 1'b0;
            r_mul_first <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
            msg_out     <= '0;
        end else begin
            r_state <= w_state_next;
            done    <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_n    <= n;
                        r_base <= msg_in;
                        r_exp  <= encrypt_decrypt ? key_e : key_d;
                        busy   <= 1'b1;
                    end
                end
                CHECK: begin
                    r_err       <= w_bad;
                    r_result    <= WIDTH'(1);
                    r_cnt       <= '0;
                    r_mul_first <= 1'b1;
                end
                MUL: r_mul_first <= 1'b0;
                NEXT: begin
                    r_base <= w_p_b;
                    if (r_exp[0])
                        r_result <= w_p_a;
                    r_exp       <= r_exp >> 1;
                    r_cnt       <= r_cnt + CNT_W'(1);
                    r_mul_first <= 1'b1;
                end
                DONE: begin
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    error   <= r_err;
                    msg_out <= r_err ? '0 : r_result;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rsa_modexp_core.sv
`default_nettype none
// ============================================================================
// Module      : tb_rsa_modexp_core
// Description : Randomized self-checking bench for rsa_modexp_core at
//               WIDTH=16, EXP_WIDTH=16 against an arithmetic reference.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rsa_modexp_core;

    localparam int W   = 16;
    localparam int E   = 16;
    localparam int LAT = 2 + E * (W + 1);

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         encrypt_decrypt;
    logic [W-1:0] n;
    logic [E-1:0] key_e;
    logic [E-1:0] key_d;
    logic [W-1:0] msg_in;
    logic         busy;
    logic         done;
    logic         error;
    logic [W-1:0] msg_out;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    rsa_modexp_core #(.WIDTH(W), .EXP_WIDTH(E)) dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .encrypt_decrypt (encrypt_decrypt),
        .n               (n),
        .key_e           (key_e),
        .key_d           (key_d),
        .msg_in          (msg_in),
        .busy            (busy),
        .done            (done),
        .error           (error),
        .msg_out         (msg_out)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] expv);
        n_tests++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, expv);
        end
    endtask

    function automatic longint ref_pow(input longint b, input longint e, input longint m);
        longint r = 1;
        b = b % m;
        while (e > 0) begin
            if (e % 2 == 1) r = (r * b) % m;
            b = (b * b) % m;
            e = e / 2;
        end
        return r % m;
    endfunction

    // pulse_at > 0: re-pulse start with scrambled operands that many cycles in.
    task automatic run_job(input string tag, input logic [W-1:0] nn, input logic [W-1:0] mm,
                           input logic [E-1:0] ke, input logic [E-1:0] kd, input logic enc,
                           input int pulse_at);
        int     cyc;
        logic   bad;
        longint exp_out;
        int     exp_lat;
        bad     = (nn < 2) || (mm >= nn);
        exp_out = bad ? 0 : ref_pow(longint'(mm), longint'(enc ? ke : kd), longint'(nn));
        exp_lat = bad ? 2 : LAT;
        @(negedge clk);
        n = nn; msg_in = mm; key_e = ke; key_d = kd; encrypt_decrypt = enc; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc   = 0;
        check({tag, "_busy"}, 64'(busy), 64'd1);
        while (!done && cyc < 2 * LAT) begin
            @(negedge clk);
            cyc++;
            if (cyc == pulse_at) begin
                start = 1'b1;
                n = W'($urandom); msg_in = W'($urandom);
                key_e = E'($urandom); key_d = E'($urandom);
                encrypt_decrypt = ~enc;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        check({tag, "_latency"}, 64'(cyc), 64'(exp_lat));
        check({tag, "_msg_out"}, 64'(msg_out), 64'(exp_out));
        check({tag, "_error"}, 64'(error), 64'(bad));
        check({tag, "_busy_at_done"}, 64'(busy), 64'd0);
        @(negedge clk);
        check({tag, "_done_pulse"}, 64'(done), 64'd0);
        check({tag, "_hold"}, 64'(msg_out), 64'(exp_out));
    endtask

    initial begin
        int dcount;
        logic [W-1:0] rn;
        logic [W-1:0] rm;
        reset = 1'b0; start = 1'b0; encrypt_decrypt = 1'b0;
        n = '0; key_e = '0; key_d = '0; msg_in = '0;
        repeat (3) @(negedge clk);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_error", 64'(error), 64'd0);
        check("reset_msg_out", 64'(msg_out), 64'd0);
        reset = 1'b1;

        run_job("enc_3233", 16'd3233, 16'd65, 16'd17, 16'd2753, 1'b1, 0);
        run_job("dec_3233", 16'd3233, 16'd2790, 16'd17, 16'd2753, 1'b0, 0);
        run_job("msg_ge_n", 16'd3233, 16'd3233, 16'd17, 16'd2753, 1'b1, 0);
        run_job("n_is_1", 16'd1, 16'd0, 16'd17, 16'd2753, 1'b1, 0);
        run_job("exp_zero", 16'd3233, 16'd1234, 16'd0, 16'd2753, 1'b1, 0);
        run_job("msg_zero", 16'd3233, 16'd0, 16'd17, 16'd2753, 1'b1, 0);
        run_job("full_exp", 16'd65521, 16'd65520, 16'hFFFF, 16'h8001, 1'b0, 0);
        run_job("restart_ignored", 16'd3233, 16'd65, 16'd17, 16'd2753, 1'b1, 100);

        // Abort a job with reset partway through.
        @(negedge clk);
        n = 16'd3233; msg_in = 16'd99; key_e = 16'd17; encrypt_decrypt = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (99) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("midreset_busy", 64'(busy), 64'd0);
        check("midreset_msg_out", 64'(msg_out), 64'd0);
        check("midreset_done", 64'(done), 64'd0);
        reset  = 1'b1;
        dcount = 0;
        repeat (LAT + 10) begin
            @(negedge clk);
            if (done) dcount++;
        end
        check("midreset_no_done", 64'(dcount), 64'd0);
        run_job("after_reset", 16'd3233, 16'd99, 16'd17, 16'd2753, 1'b1, 0);

        for (int i = 0; i < 16; i++) begin
            rn = W'($urandom_range(2, 65535));
            rm = (i % 5 == 4) ? W'($urandom_range(int'(rn), 65535)) : W'($urandom_range(0, int'(rn) - 1));
            run_job($sformatf("rand%0d", i), rn, rm, E'($urandom), E'($urandom), 1'($urandom), 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
